// File: rtl/mips_boot_loader_pkg.sv
// Shared definitions for the Mips boot loader: FSM state encoding and word packing geometry.
package mips_boot_loader_pkg;

    typedef enum logic [2:0] {
        HDR_HI = 3'd0,
        HDR_LO = 3'd1,
        DATA   = 3'd2,
        WRITE  = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam int         WORD_BYTES    = 4;
    localparam logic [1:0] LAST_BYTE_IDX = 2'(WORD_BYTES - 1);

endpackage

// File: rtl/mips_boot_loader_byte_packer.sv
// Packs accepted stream bytes MSB-first into a 32-bit word; flags the byte that completes a word.
module mips_boot_loader_byte_packer
    import mips_boot_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [7:0]  din,
    output logic [31:0] word_next,
    output logic        word_ready
);

    logic [31:0] shift_r;
    logic [1:0]  idx_r;

    // Next packed word and completion flag for the byte currently offered
    always_comb begin
        word_next  = {shift_r[23:0], din};
        word_ready = 1'b0;
        if (load && (idx_r == LAST_BYTE_IDX)) begin
            word_ready = 1'b1;
        end else begin
            word_ready = 1'b0;
        end
    end

    // Shift register and byte index; idx wraps naturally after the fourth byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_r <= 32'd0;
            idx_r   <= 2'd0;
        end else if (load) begin
            shift_r <= word_next;
            idx_r   <= idx_r + 2'd1;
        end else begin
            shift_r <= shift_r;
            idx_r   <= idx_r;
        end
    end

endmodule

// File: rtl/mips_boot_loader.sv
// Boot loader: unpacks a counted byte frame into 32-bit words, writes them to memory, then raises Start.
module mips_boot_loader
    import mips_boot_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int BASE_ADDR  = 0,
    parameter int MAX_WORDS  = 1024
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [7:0]            InData,
    input  logic                  InValid,
    output logic                  InReady,
    output logic                  MemWrite,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    output logic [31:0]           MemWriteData,
    output logic                  Start,
    output logic                  Busy,
    output logic                  Overflow
);

    state_t      state_r;
    logic [7:0]  cnt_hi_r;
    logic [15:0] cnt_r;
    logic [15:0] w_r;

    logic        accept_s;
    logic        load_s;
    logic [15:0] hdr_n_s;
    logic [31:0] word_next_s;
    logic        word_ready_s;

    // Byte transfer qualifiers and the word count as it completes in HDR_LO
    always_comb begin
        accept_s = InValid && InReady;
        load_s   = 1'b0;
        hdr_n_s  = {cnt_hi_r, InData};
        if (accept_s && (state_r == DATA)) begin
            load_s = 1'b1;
        end else begin
            load_s = 1'b0;
        end
    end

    mips_boot_loader_byte_packer u_packer (
        .clk        (Clk),
        .rst        (Rst),
        .load       (load_s),
        .din        (InData),
        .word_next  (word_next_s),
        .word_ready (word_ready_s)
    );

    // Load FSM with counters; every output is a register updated on the transition that needs it
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_r      <= HDR_HI;
            cnt_hi_r     <= 8'd0;
            cnt_r        <= 16'd0;
            w_r          <= 16'd0;
            InReady      <= 1'b1;
            MemWrite     <= 1'b0;
            MemAddr      <= '0;
            MemWriteData <= 32'd0;
            Start        <= 1'b0;
            Busy         <= 1'b0;
            Overflow     <= 1'b0;
        end else begin
            case (state_r)
                HDR_HI: begin
                    if (accept_s) begin
                        cnt_hi_r <= InData;
                        Busy     <= 1'b1;
                        state_r  <= HDR_LO;
                    end
                end
                HDR_LO: begin
                    if (accept_s) begin
                        cnt_r    <= hdr_n_s;
                        w_r      <= 16'd0;
                        Overflow <= (32'(hdr_n_s) > 32'(MAX_WORDS));
                        if (hdr_n_s == 16'd0) begin
                            state_r <= DONE;
                            Start   <= 1'b1;
                            Busy    <= 1'b0;
                            InReady <= 1'b0;
                        end else begin
                            state_r <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (word_ready_s) begin
                        state_r      <= WRITE;
                        InReady      <= 1'b0;
                        // Words past MAX_WORDS are still consumed, just not written
                        MemWrite     <= (32'(w_r) < 32'(MAX_WORDS));
                        MemAddr      <= ADDR_WIDTH'(32'(BASE_ADDR) + 32'(w_r));
                        MemWriteData <= word_next_s;
                    end
                end
                WRITE: begin
                    MemWrite <= 1'b0;
                    w_r      <= w_r + 16'd1;
                    if ((w_r + 16'd1) == cnt_r) begin
                        state_r <= DONE;
                        Start   <= 1'b1;
                        Busy    <= 1'b0;
                    end else begin
                        state_r <= DATA;
                        InReady <= 1'b1;
                    end
                end
                DONE: begin
                    state_r <= DONE;
                end
                default: begin
                    state_r  <= HDR_HI;
                    InReady  <= 1'b1;
                    MemWrite <= 1'b0;
                    Start    <= 1'b0;
                    Busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_boot_loader.sv
// Directed bench: three loader instances (default, MAX_WORDS=2, BASE_ADDR=1022) share one byte stream.
module tb_mips_boot_loader;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [7:0] InData;
    logic       InValid;

    logic        InReady_a, MemWrite_a, Start_a, Busy_a, Overflow_a;
    logic [9:0]  MemAddr_a;
    logic [31:0] MemWriteData_a;
    logic        InReady_b, MemWrite_b, Start_b, Busy_b, Overflow_b;
    logic [9:0]  MemAddr_b;
    logic [31:0] MemWriteData_b;
    logic        InReady_c, MemWrite_c, Start_c, Busy_c, Overflow_c;
    logic [9:0]  MemAddr_c;
    logic [31:0] MemWriteData_c;

    int n_checks = 0;
    int n_fail   = 0;

    logic [41:0] q_a[$];
    logic [41:0] q_b[$];
    logic [41:0] q_c[$];

    always #5 Clk = ~Clk;

    mips_boot_loader dut_a (
        .Clk(Clk), .Rst(Rst), .InData(InData), .InValid(InValid), .InReady(InReady_a),
        .MemWrite(MemWrite_a), .MemAddr(MemAddr_a), .MemWriteData(MemWriteData_a),
        .Start(Start_a), .Busy(Busy_a), .Overflow(Overflow_a)
    );

    mips_boot_loader #(.MAX_WORDS(2)) dut_b (
        .Clk(Clk), .Rst(Rst), .InData(InData), .InValid(InValid), .InReady(InReady_b),
        .MemWrite(MemWrite_b), .MemAddr(MemAddr_b), .MemWriteData(MemWriteData_b),
        .Start(Start_b), .Busy(Busy_b), .Overflow(Overflow_b)
    );

    mips_boot_loader #(.BASE_ADDR(1022)) dut_c (
        .Clk(Clk), .Rst(Rst), .InData(InData), .InValid(InValid), .InReady(InReady_c),
        .MemWrite(MemWrite_c), .MemAddr(MemAddr_c), .MemWriteData(MemWriteData_c),
        .Start(Start_c), .Busy(Busy_c), .Overflow(Overflow_c)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Write monitor: capture every strobe and require InReady low while writing
    always @(negedge Clk) begin
        if (MemWrite_a === 1'b1) begin
            q_a.push_back({MemAddr_a, MemWriteData_a});
            check_eq("ready_in_write_a", 32'(InReady_a), 32'd0);
        end
        if (MemWrite_b === 1'b1) begin
            q_b.push_back({MemAddr_b, MemWriteData_b});
            check_eq("ready_in_write_b", 32'(InReady_b), 32'd0);
        end
        if (MemWrite_c === 1'b1) begin
            q_c.push_back({MemAddr_c, MemWriteData_c});
            check_eq("ready_in_write_c", 32'(InReady_c), 32'd0);
        end
    end

    task automatic check_writes(input string tag, input logic [41:0] got[$], input logic [41:0] exp[$]);
        check_eq({tag, "_count"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            check_eq({tag, "_addr"}, 32'(got[i][41:32]), 32'(exp[i][41:32]));
            check_eq({tag, "_data"}, got[i][31:0], exp[i][31:0]);
        end
    endtask

    // Offer one byte after a gap; returns at the falling edge following the transfer
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit done = 1'b0;
        InValid = 1'b0;
        repeat (gap) @(negedge Clk);
        InData  = b;
        InValid = 1'b1;
        for (int k = 0; k < 50 && !done; k++) begin
            if (InReady_a === 1'b1) done = 1'b1;
            @(negedge Clk);
        end
        if (!done) check_eq("accept_timeout", 32'(InReady_a), 32'd1);
        InValid = 1'b0;
    endtask

    task automatic send_stream(input logic [7:0] bytes[$], input int max_gap);
        for (int i = 0; i < bytes.size(); i++) begin
            send_byte(bytes[i], (max_gap == 0) ? 0 : int'($urandom_range(max_gap, 0)));
        end
    endtask

    task automatic do_reset();
        InValid = 1'b0;
        Rst     = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        q_a.delete();
        q_b.delete();
        q_c.delete();
    endtask

    initial begin
        logic [7:0]  s2[$];
        logic [7:0]  s3[$];
        logic [41:0] exp[$];

        s2 = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h01};
        s3 = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
               8'h99, 8'hAA, 8'hBB, 8'hCC};
        InData  = 8'h00;
        InValid = 1'b0;
        Rst     = 1'b1;
        #1;
        // flags packed as {InReady, MemWrite, Start, Busy, Overflow}
        check_eq("reset_flags_a", 32'({InReady_a, MemWrite_a, Start_a, Busy_a, Overflow_a}), 32'h10);
        check_eq("reset_flags_b", 32'({InReady_b, MemWrite_b, Start_b, Busy_b, Overflow_b}), 32'h10);
        check_eq("reset_flags_c", 32'({InReady_c, MemWrite_c, Start_c, Busy_c, Overflow_c}), 32'h10);
        check_eq("reset_addr_a", 32'(MemAddr_a), 32'd0);
        check_eq("reset_data_a", MemWriteData_a, 32'd0);
        do_reset();

        // Reset in the middle of a word, then a clean reload
        send_stream('{8'h00, 8'h02, 8'hDE, 8'hAD}, 0);
        check_eq("mid_busy", 32'(Busy_a), 32'd1);
        Rst = 1'b1;
        #1;
        check_eq("midrst_flags_a", 32'({InReady_a, MemWrite_a, Start_a, Busy_a, Overflow_a}), 32'h10);
        @(negedge Clk);
        Rst = 1'b0;

        // N=2 with no gaps
        send_stream(s2, 0);
        check_eq("n2_write_strobe", 32'(MemWrite_a), 32'd1);
        check_eq("n2_start_during_write", 32'(Start_a), 32'd0);
        @(negedge Clk);
        check_eq("n2_done_flags_a", 32'({InReady_a, MemWrite_a, Start_a, Busy_a, Overflow_a}), 32'h04);
        exp = '{{10'd0, 32'hDEADBEEF}, {10'd1, 32'h00000001}};
        check_writes("n2_a", q_a, exp);
        exp = '{{10'd1022, 32'hDEADBEEF}, {10'd1023, 32'h00000001}};
        check_writes("n2_c", q_c, exp);
        // Bytes offered in DONE are ignored
        InValid = 1'b1;
        InData  = 8'h55;
        repeat (3) @(negedge Clk);
        InValid = 1'b0;
        check_eq("done_no_write", 32'(q_a.size()), 32'd2);
        check_eq("done_start_held", 32'(Start_a), 32'd1);

        // N=0: Start right after the second header byte
        do_reset();
        send_stream('{8'h00, 8'h00}, 0);
        check_eq("n0_flags_a", 32'({InReady_a, MemWrite_a, Start_a, Busy_a, Overflow_a}), 32'h04);
        check_eq("n0_no_write", 32'(q_a.size()), 32'd0);

        // N=2 with random stalls of 0-5 cycles
        do_reset();
        send_stream(s2, 5);
        @(negedge Clk);
        check_eq("gap_start", 32'(Start_a), 32'd1);
        exp = '{{10'd0, 32'hDEADBEEF}, {10'd1, 32'h00000001}};
        check_writes("gap_a", q_a, exp);

        // N=3: overflow on dut_b, address wrap on dut_c
        do_reset();
        send_stream(s3, 0);
        @(negedge Clk);
        check_eq("n3_flags_a", 32'({InReady_a, MemWrite_a, Start_a, Busy_a, Overflow_a}), 32'h04);
        check_eq("n3_flags_b", 32'({InReady_b, MemWrite_b, Start_b, Busy_b, Overflow_b}), 32'h05);
        check_eq("n3_flags_c", 32'({InReady_c, MemWrite_c, Start_c, Busy_c, Overflow_c}), 32'h04);
        exp = '{{10'd0, 32'h11223344}, {10'd1, 32'h55667788}, {10'd2, 32'h99AABBCC}};
        check_writes("n3_a", q_a, exp);
        exp = '{{10'd0, 32'h11223344}, {10'd1, 32'h55667788}};
        check_writes("n3_b", q_b, exp);
        exp = '{{10'd1022, 32'h11223344}, {10'd1023, 32'h55667788}, {10'd0, 32'h99AABBCC}};
        check_writes("n3_c", q_c, exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
